// File: rtl/freq_pkg.sv
// ---------------------------------------------------------------------------
// freq_pkg
// Shared definitions for the symbol frequency counter:
//   - state_t      : controller states IDLE / COUNT / REQ
//   - DEF_NUM_SYM  : default number of symbol bins
//   - DEF_SYM_W    : default symbol width
//   - DEF_CNT_W    : default per-bin count width
// ---------------------------------------------------------------------------
package freq_pkg;

  localparam int DEF_NUM_SYM = 10;
  localparam int DEF_SYM_W   = 4;
  localparam int DEF_CNT_W   = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2
  } state_t;

endpackage

// File: rtl/freq_bin.sv
// ---------------------------------------------------------------------------
// freq_bin
// One histogram bin: a counter that clears on 'clear' and steps on 'inc'.
// Build option FREQCNT_SAT_EN: when defined, the counter holds at its maximum
// and 'sat' flags an increment attempted at the maximum; when undefined the
// counter wraps and 'sat' is tied low.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   clear  in   zero the count (wins over inc)
//   inc    in   add one to the count
//   count  out  current count, CNT_W bits
//   sat    out  increment attempted while at maximum (saturating build only)
// ---------------------------------------------------------------------------
module freq_bin #(
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

`ifdef FREQCNT_SAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic at_max;
  assign at_max = (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

  // Combinational: the parent makes the flag sticky.
  assign sat = inc && at_max;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign sat = 1'b0;
`endif

endmodule

// File: rtl/symbol_freq_counter.sv
// ---------------------------------------------------------------------------
// symbol_freq_counter
// Builds a histogram of the symbols of one frame and offers it to a coder
// through a req/ack handshake.
//
// Handshake: req_coding rises the cycle after the frame's last symbol
// (start_done) and stays high, with data_out frozen, until ack_coding is
// sampled high; the controller then returns to IDLE and req_coding drops on
// the following cycle. ack_coding is ignored when no request is pending.
//
// Build option FREQCNT_SAT_EN: saturating bins plus a sticky sat_flag;
// otherwise bins wrap and sat_flag stays 0.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   start       in   pulse opening (or restarting) a frame
//   start_done  in   pulse marking the last symbol of a frame
//   in_valid    in   data_in qualifier
//   data_in     in   symbol, SYM_W bits
//   req_coding  out  result valid / request to the coder
//   ack_coding  in   coder acknowledge
//   data_out    out  NUM_SYM entries {symbol index, count}, entry 0 in LSBs
//   busy        out  high while counting or requesting
//   range_err   out  sticky per frame: a valid symbol >= NUM_SYM was seen
//   sat_flag    out  sticky per frame: some bin saturated
//   state_dbg   out  current controller state
// ---------------------------------------------------------------------------
module symbol_freq_counter
  import freq_pkg::*;
#(
  parameter int NUM_SYM = DEF_NUM_SYM,
  parameter int SYM_W   = DEF_SYM_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             start_done,
  input  logic                             in_valid,
  input  logic [SYM_W-1:0]                 data_in,
  output logic                             req_coding,
  input  logic                             ack_coding,
  output logic [NUM_SYM*(SYM_W+CNT_W)-1:0] data_out,
  output logic                             busy,
  output logic                             range_err,
  output logic                             sat_flag,
  output state_t                           state_dbg
);

  localparam int ENT_W = SYM_W + CNT_W;

  state_t state_q, state_d;

  logic               clear;
  logic               accept;
  logic               sym_in_range;
  logic [NUM_SYM-1:0] bin_sat;
  logic               range_err_q;
  logic               sat_flag_q;

  // start opens or restarts a frame from IDLE or COUNT; it is dead in REQ.
  assign clear = start && (state_q != REQ);

  // The symbol that arrives with start is never counted.
  assign accept = (state_q == COUNT) && !start && in_valid;

  assign sym_in_range = (32'(data_in) < 32'(NUM_SYM));

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = COUNT;
      end
      COUNT: begin
        // A coincident start wins: the frame restarts and start_done is dropped.
        if (start)           state_d = COUNT;
        else if (start_done) state_d = REQ;
      end
      REQ: begin
        if (ack_coding) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Sticky per-frame flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      range_err_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else if (clear) begin
      range_err_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      if (accept && !sym_in_range) range_err_q <= 1'b1;
      if (|bin_sat)                sat_flag_q  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Histogram bins
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SYM; gi++) begin : g_bin
    logic [CNT_W-1:0] bin_cnt;

    freq_bin #(
      .CNT_W (CNT_W)
    ) u_bin (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .inc   (accept && (data_in == SYM_W'(gi))),
      .count (bin_cnt),
      .sat   (bin_sat[gi])
    );

    assign data_out[gi*ENT_W +: ENT_W] = {SYM_W'(gi), bin_cnt};
  end

  assign req_coding = (state_q == REQ);
  assign busy       = (state_q != IDLE);
  assign range_err  = range_err_q;
  assign sat_flag   = sat_flag_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_symbol_freq_counter.sv
// ---------------------------------------------------------------------------
// tb_symbol_freq_counter
// Directed bench for symbol_freq_counter: a default-parameter instance for
// the main frame, handshake, range, restart and reset cases, plus a CNT_W=3
// instance for the saturate/wrap case. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_symbol_freq_counter;
  import freq_pkg::*;

  localparam int NS   = 10;
  localparam int SW   = 4;
  localparam int CW   = 15;
  localparam int EW   = SW + CW;
  localparam int DW   = NS * EW;
  localparam int CW_S = 3;
  localparam int EW_S = SW + CW_S;
  localparam int DW_S = NS * EW_S;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- main instance ----------------
  logic          start, start_done, in_valid, ack_coding;
  logic [SW-1:0] data_in;
  logic          req_coding, busy, range_err, sat_flag;
  logic [DW-1:0] data_out;
  state_t        state_dbg;

  symbol_freq_counter #(.NUM_SYM(NS), .SYM_W(SW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_done (start_done),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .req_coding (req_coding),
    .ack_coding (ack_coding),
    .data_out   (data_out),
    .busy       (busy),
    .range_err  (range_err),
    .sat_flag   (sat_flag),
    .state_dbg  (state_dbg)
  );

  // ---------------- narrow-count instance ----------------
  logic            s_start, s_done, s_valid, s_ack;
  logic [SW-1:0]   s_data;
  logic            s_req, s_busy, s_range, s_sat;
  logic [DW_S-1:0] s_out;
  state_t          s_state;

  symbol_freq_counter #(.NUM_SYM(NS), .SYM_W(SW), .CNT_W(CW_S)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s_start),
    .start_done (s_done),
    .in_valid   (s_valid),
    .data_in    (s_data),
    .req_coding (s_req),
    .ack_coding (s_ack),
    .data_out   (s_out),
    .busy       (s_busy),
    .range_err  (s_range),
    .sat_flag   (s_sat),
    .state_dbg  (s_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int exp_m [NS];

  function automatic logic [DW-1:0] pack_m();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) r[i*EW +: EW] = {SW'(i), CW'(exp_m[i])};
    return r;
  endfunction

  function automatic logic [DW_S-1:0] pack_s(input int c2);
    logic [DW_S-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) r[i*EW_S +: EW_S] = {SW'(i), CW_S'((i == 2) ? c2 : 0)};
    return r;
  endfunction

  task automatic clr_exp();
    for (int i = 0; i < NS; i++) exp_m[i] = 0;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sd, input logic v, input int d);
    start      = st;
    start_done = sd;
    in_valid   = v;
    data_in    = SW'(d);
  endtask

  int freq_tab [9] = '{5, 1, 3, 2, 9, 7, 4, 8, 6};
  logic [DW-1:0] held;
  logic [EW-1:0] ent4;
  int   sat_cnt;
  logic sat_exp;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    ack_coding = 1'b0;
    s_start = 0; s_done = 0; s_valid = 0; s_data = '0; s_ack = 0;
    clr_exp();
    step();
    step();

    // ---- reset state ----
    chk("rst_req", req_coding, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_range", range_err, 1'b0);
    chk("rst_sat", sat_flag, 1'b0);
    chk("rst_data", data_out, pack_m());
    rst_n = 1'b1;
    step();

    // ---- main frame; symbol on the start cycle is not counted ----
    drive(1, 0, 1, 3);
    step();
    chk("start_busy", busy, 1'b1);
    for (int s = 0; s < 9; s++) begin
      if (s == 4) begin
        // Out-of-range symbols and an unqualified cycle: none may be counted.
        drive(0, 0, 1, 12); step();
        drive(0, 0, 1, 15); step();
        drive(0, 0, 1, 10); step();
        drive(0, 0, 0, 2);  step();
        chk("range_set", range_err, 1'b1);
      end
      for (int k = 0; k < freq_tab[s]; k++) begin
        drive(0, (s == 8 && k == freq_tab[s] - 1), 1, s);
        exp_m[s]++;
        if (s == 8 && k == freq_tab[s] - 1) chk("req_early", req_coding, 1'b0);
        step();
      end
    end
    drive(0, 0, 0, 0);
    chk("req_rise", req_coding, 1'b1);
    chk("frame_data", data_out, pack_m());
    ent4 = data_out[4*EW +: EW];
    chk("entry4", ent4, {4'd4, 15'd9});
    chk("range_keep", range_err, 1'b1);

    // ---- hold ack low 20 cycles; start/start_done/in_valid ignored in REQ ----
    held = data_out;
    for (int c = 0; c < 20; c++) begin
      drive((c == 5), (c == 7), (c >= 5 && c <= 9), 0);
      step();
      chk("req_hold", req_coding, 1'b1);
      chk("data_hold", data_out, held);
    end
    drive(0, 0, 0, 0);
    ack_coding = 1'b1;
    step();
    ack_coding = 1'b0;
    chk("ack_req", req_coding, 1'b0);
    chk("ack_busy", busy, 1'b0);
    chk("idle_data", data_out, pack_m());

    // ---- start_done and ack in IDLE are ignored ----
    drive(0, 1, 1, 1);
    ack_coding = 1'b1;
    step();
    drive(0, 0, 0, 0);
    ack_coding = 1'b0;
    step();
    chk("idle_sd_busy", busy, 1'b0);
    chk("idle_sd_req", req_coding, 1'b0);
    chk("idle_sd_data", data_out, pack_m());

    // ---- start+start_done in IDLE opens a frame; restart mid-frame ----
    drive(1, 1, 1, 0);
    step();
    clr_exp();
    chk("open_busy", busy, 1'b1);
    chk("open_req", req_coding, 1'b0);
    chk("open_clear", data_out, pack_m());
    chk("open_range", range_err, 1'b0);
    drive(0, 0, 1, 0); step();
    drive(0, 0, 1, 2); step();
    drive(0, 0, 1, 3); step();
    drive(0, 0, 1, 4); step();
    drive(1, 1, 1, 5);
    step();
    chk("restart_busy", busy, 1'b1);
    chk("restart_req", req_coding, 1'b0);
    chk("restart_clear", data_out, pack_m());
    drive(0, 0, 1, 1); step();
    drive(0, 0, 1, 1); step();
    drive(0, 1, 1, 1); step();
    drive(0, 0, 0, 0);
    exp_m[1] = 3;
    chk("restart_req2", req_coding, 1'b1);
    chk("restart_data", data_out, pack_m());
    ack_coding = 1'b1;
    step();
    ack_coding = 1'b0;

    // ---- reset during REQ ----
    drive(1, 0, 0, 0); step();
    drive(0, 0, 1, 7); step();
    drive(0, 0, 1, 7); step();
    drive(0, 1, 1, 7); step();
    drive(0, 0, 0, 0);
    clr_exp();
    exp_m[7] = 3;
    chk("pre_rst_req", req_coding, 1'b1);
    chk("pre_rst_data", data_out, pack_m());
    rst_n = 1'b0;
    step();
    clr_exp();
    chk("mid_rst_req", req_coding, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", data_out, pack_m());
    rst_n = 1'b1;
    ack_coding = 1'b1;
    step();
    ack_coding = 1'b0;
    step();
    chk("late_ack_req", req_coding, 1'b0);
    chk("late_ack_busy", busy, 1'b0);

    // ---- narrow counter: symbol 2 ten times ----
`ifdef FREQCNT_SAT_EN
    sat_cnt = 7;
    sat_exp = 1'b1;
`else
    sat_cnt = 2;
    sat_exp = 1'b0;
`endif
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1;
      s_data  = 4'd2;
      s_done  = (k == 9);
      step();
    end
    s_valid = 1'b0;
    s_done  = 1'b0;
    chk("sat_req", s_req, 1'b1);
    chk("sat_data", s_out, pack_s(sat_cnt));
    chk("sat_flag", s_sat, sat_exp);
    chk("main_sat_zero", sat_flag, 1'b0);
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    chk("sat_ack_req", s_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/symbol_freq_counter.md
SYMBOL_FREQ_COUNTER -- requirements
Module: symbol_freq_counter

Interface
REQ-001 SHALL have parameter NUM_SYM, default 10, number of symbol bins.
REQ-002 SHALL have parameter SYM_W, default 4, symbol width; NUM_SYM <= 2**SYM_W.
REQ-003 SHALL have parameter CNT_W, default 15, per-bin count width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse that opens a frame.
REQ-007 SHALL have port start_done  input  1  one-cycle pulse that arrives with the last symbol.
REQ-008 SHALL have port in_valid  input  1  data_in qualifier.
REQ-009 SHALL have port data_in  input  SYM_W  symbol.
REQ-010 SHALL have port req_coding  output  1  result valid, request to the coder.
REQ-011 SHALL have port ack_coding  input  1  coder acknowledge.
REQ-012 SHALL have port data_out  output  NUM_SYM*(SYM_W+CNT_W)  packed entries, entry i = {i[SYM_W-1:0], count_i}, entry 0 in the LSBs.
REQ-013 SHALL have port busy  output  1  high in COUNT or REQ.
REQ-014 SHALL have port range_err  output  1  sticky per frame; a valid symbol >= NUM_SYM was seen.
REQ-015 SHALL have port sat_flag  output  1  sticky per frame; some bin saturated.

Function
REQ-016 SHALL implement the states IDLE, COUNT and REQ.
REQ-017 IDLE->COUNT SHALL occur on start, clearing all bins, range_err and sat_flag on the same edge.
REQ-018 The symbol on the start cycle SHALL NOT be counted.
REQ-019 In COUNT, each cycle with in_valid=1 and data_in<NUM_SYM SHALL increment bin[data_in] by 1.
REQ-020 A valid data_in>=NUM_SYM SHALL be dropped and SHALL set range_err.
REQ-021 In COUNT, start_done SHALL count its own symbol when valid; COUNT->REQ follows, and req_coding is high on the next cycle.
REQ-022 start in COUNT SHALL restart the frame: bins cleared, that cycle's symbol not counted, state stays COUNT.
REQ-023 start and start_done together in COUNT SHALL be treated as a restart; start_done is ignored.
REQ-024 start_done in IDLE SHALL be ignored.
REQ-025 start and start_done together in IDLE SHALL open a frame only.
REQ-026 In REQ, req_coding SHALL stay high and data_out stable until ack_coding=1 is sampled; then go to IDLE with req_coding low the next cycle.
REQ-027 start, start_done and in_valid SHALL be ignored in REQ.
REQ-028 In IDLE, data_out SHALL hold the last frame's result.
REQ-029 ack_coding outside REQ SHALL be ignored.
REQ-030 Frame throughput SHALL be 1 symbol/cycle with no stall input.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE with all bins 0, req_coding=0, busy=0, range_err=0 and sat_flag=0.
REQ-032 Reset mid-frame or mid-handshake SHALL discard the frame and de-assert req_coding without waiting for ack.

Configuration
REQ-033 With FREQCNT_SAT_EN defined, a bin at 2**CNT_W-1 SHALL hold its value on further increments and SHALL set sat_flag.
REQ-034 Without FREQCNT_SAT_EN, bins SHALL wrap modulo 2**CNT_W and sat_flag SHALL be tied 0.

Structure
REQ-035 A package freq_pkg SHALL hold the state enum (IDLE, COUNT, REQ) and the default NUM_SYM/SYM_W/CNT_W constants.
REQ-036 A sub-module freq_bin (clear, inc, count, sat) SHALL be instantiated NUM_SYM times via generate.

Verification
REQ-037 Defaults: start; symbols 0..8 with counts 5,1,3,2,9,7,4,8,6, start_done on the last -> req_coding 1 cycle after start_done; entries 0..9 counts {5,1,3,2,9,7,4,8,6,0}; entry 4 = {4'd4,15'd9}.
REQ-038 Hold ack_coding low 20 cycles, then pulse it -> req_coding and data_out stable throughout; req_coding=0 and busy=0 the cycle after ack.
REQ-039 Inject symbols 12 and 15 with in_valid mid-frame -> range_err=1; all bins unchanged by them.
REQ-040 CNT_W=3 with FREQCNT_SAT_EN, symbol 2 presented 10 times -> bin 2 = 7 and sat_flag=1; without the macro -> bin 2 = 2 and sat_flag=0.
REQ-041 start mid-frame after 4 symbols, then 3 symbols of 1 and start_done -> bin 1 = 3, all others 0.
REQ-042 rst_n low during REQ -> req_coding=0 and all bins 0 next cycle; a later ack_coding is ignored.
